// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single RAM port.
// Each side gets one request slot; one RAM transaction is in flight at a time.
module ram_arbiter #(
  parameter int                 ADDR_W  = 32,
  parameter int                 DATA_W  = 32,
  parameter int                 TIMEOUT = 255,
  parameter logic [DATA_W-1:0]  TO_DATA = DATA_W'(32'hdeadbeef)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] a_ramAddress,
  input  logic [DATA_W-1:0] a_ramOut,
  input  logic              a_readReq,
  input  logic              a_writeReq,
  output logic [DATA_W-1:0] a_ramIn,
  output logic              a_readAck,
  output logic              a_writeAck,
  input  logic [ADDR_W-1:0] b_ramAddress,
  input  logic [DATA_W-1:0] b_ramOut,
  input  logic              b_readReq,
  input  logic              b_writeReq,
  output logic [DATA_W-1:0] b_ramIn,
  output logic              b_readAck,
  output logic              b_writeAck,
  output logic [ADDR_W-1:0] m_ramAddress,
  output logic [DATA_W-1:0] m_ramOut,
  output logic              m_readReq,
  output logic              m_writeReq,
  input  logic [DATA_W-1:0] m_ramIn,
  input  logic              m_readAck,
  input  logic              m_writeAck,
  output logic              grant,
  output logic              busy,
  output logic [1:0]        err_overflow,
  output logic              err_timeout,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester pulses readReq/writeReq for one cycle (write wins if
  // both), then waits for a one-cycle readAck/writeAck; the RAM side is the same.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;
  state_t r_state, w_state_nx;

  logic [1:0]        w_req_rd, w_req_wr, w_free;
  logic [ADDR_W-1:0] w_in_addr [2];
  logic [DATA_W-1:0] w_in_data [2];
  logic              w_pick, w_ack_match, w_timeout, w_done, w_to;

  logic [1:0]        r_vld, r_slot_wr, r_ack_rd, r_ack_wr, r_err_ovf;
  logic [ADDR_W-1:0] r_addr [2];
  logic [DATA_W-1:0] r_data [2];
  logic [DATA_W-1:0] r_ram_in [2];
  logic              r_wr, r_grant, r_last, r_err_to, r_m_rd, r_m_wr;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_data;

  assign w_req_rd     = {b_readReq, a_readReq};
  assign w_req_wr     = {b_writeReq, a_writeReq};
  assign w_in_addr[0] = a_ramAddress;
  assign w_in_addr[1] = b_ramAddress;
  assign w_in_data[0] = a_ramOut;
  assign w_in_data[1] = b_ramOut;

  always_comb begin
    // Tie goes to whoever did not own the last transaction.
    w_pick      = (r_vld == 2'b11) ? ~r_last : ~r_vld[0];
    w_ack_match = r_wr ? m_writeAck : m_readAck;
    w_timeout   = (r_cnt == CNT_W'(TIMEOUT - 1));
    w_done      = (r_state == S_WAIT) && (w_ack_match || w_timeout);
    w_to        = (r_state == S_WAIT) && !w_ack_match && w_timeout;
    w_free      = {w_done & r_grant, w_done & ~r_grant};
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (|r_vld) w_state_nx = S_ISSUE;
      S_ISSUE: w_state_nx = S_WAIT;
      S_WAIT:  if (w_done) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  // A slot stays full until its transaction completes; completion frees it in
  // time for a request arriving on that same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld     <= '0;
      r_slot_wr <= '0;
      r_err_ovf <= '0;
      for (int i = 0; i < 2; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_req_rd[i] || w_req_wr[i]) begin
          if (!r_vld[i] || w_free[i]) begin
            r_vld[i]     <= 1'b1;
            r_slot_wr[i] <= w_req_wr[i];
            r_addr[i]    <= w_in_addr[i];
            r_data[i]    <= w_in_data[i];
          end else begin
            r_err_ovf[i] <= 1'b1;
          end
        end else if (w_free[i]) begin
          r_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant     <= 1'b0;
      r_last      <= 1'b1;
      r_wr        <= 1'b0;
      r_cnt       <= '0;
      r_m_addr    <= '0;
      r_m_data    <= '0;
      r_m_rd      <= 1'b0;
      r_m_wr      <= 1'b0;
      r_ack_rd    <= '0;
      r_ack_wr    <= '0;
      r_err_to    <= 1'b0;
      r_ram_in[0] <= '0;
      r_ram_in[1] <= '0;
    end else begin
      r_m_rd   <= 1'b0;
      r_m_wr   <= 1'b0;
      r_ack_rd <= '0;
      r_ack_wr <= '0;
      case (r_state)
        S_IDLE: begin
          if (|r_vld) begin
            r_grant  <= w_pick;
            r_wr     <= r_slot_wr[w_pick];
            r_m_addr <= r_addr[w_pick];
            r_m_data <= r_data[w_pick];
            r_m_wr   <= r_slot_wr[w_pick];
            r_m_rd   <= ~r_slot_wr[w_pick];
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          if (w_done) begin
            r_last <= r_grant;
            if (r_wr) begin
              r_ack_wr[r_grant] <= 1'b1;
            end else begin
              r_ack_rd[r_grant] <= 1'b1;
              r_ram_in[r_grant] <= w_to ? TO_DATA : m_ramIn;
            end
            if (w_to) r_err_to <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign a_ramIn      = r_ram_in[0];
  assign b_ramIn      = r_ram_in[1];
  assign a_readAck    = r_ack_rd[0];
  assign b_readAck    = r_ack_rd[1];
  assign a_writeAck   = r_ack_wr[0];
  assign b_writeAck   = r_ack_wr[1];
  assign m_ramAddress = r_m_addr;
  assign m_ramOut     = r_m_data;
  assign m_readReq    = r_m_rd;
  assign m_writeReq   = r_m_wr;
  assign grant        = r_grant;
  assign busy         = (r_state != S_IDLE);
  assign err_overflow = r_err_ovf;
  assign err_timeout  = r_err_to;
  assign dbg_state    = r_state;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single RAM port between two requesters, A and B. A is the ALU core; B is a loader, DMA or second core.
- Each requester side uses the ALU's memory handshake: single-cycle readReq/writeReq pulse, then wait for a one-cycle readAck/writeAck.
- Latches requests, grants round-robin, issues one RAM transaction at a time and routes the ack and read data back to the owner.
- Sits between the requesters and the RAM model/controller.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles in WAIT before forced completion (>=1)
- TO_DATA, 32'hdeadbeef, read data returned on timeout

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- a_ramAddress  in  ADDR_W  requester A address
- a_ramOut  in  DATA_W  requester A write data
- a_readReq  in  1  requester A read request pulse
- a_writeReq  in  1  requester A write request pulse
- a_ramIn  out  DATA_W  requester A read data
- a_readAck  out  1  requester A read done pulse
- a_writeAck  out  1  requester A write done pulse
- b_*  same seven ports for requester B
- m_ramAddress  out  ADDR_W  RAM address
- m_ramOut  out  DATA_W  RAM write data
- m_readReq  out  1  RAM read request
- m_writeReq  out  1  RAM write request
- m_ramIn  in  DATA_W  RAM read data
- m_readAck  in  1  RAM read ack
- m_writeAck  in  1  RAM write ack
- grant  out  1  owner of current or last transaction (0=A, 1=B)
- busy  out  1  high in ISSUE/WAIT
- err_overflow  out  2  sticky per requester: request dropped
- err_timeout  out  1  sticky: a transaction timed out

Behaviour:
- Reset (async, reset_n=0): all outputs 0, pending slots empty, state IDLE, last_grant=B (so A wins first tie), timeout counter 0.
- Capture, per requester: on a clk edge with readReq|writeReq high and that slot empty, latch address, data and type.
  - writeReq has priority if both readReq and writeReq are high.
  - If the slot is full (pending or in flight): drop the request and set the err_overflow bit.
  - Slot frees at completion. A new request may be captured on the same edge the previous one completes.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - A request captured this edge is not visible until the next edge.
  - Only one pending: grant it.
  - Both pending: grant the one that is not last_grant.
  - On grant: register m_ramAddress, m_ramOut and m_readReq or m_writeReq = 1; set grant; go ISSUE.
- ISSUE: exactly one cycle; deassert m_readReq/m_writeReq; clear timeout counter; go WAIT.
- WAIT:
  - Ack matching the issued type (m_readAck for reads, m_writeAck for writes) ends the transaction. A non-matching ack is ignored.
  - Read completion: owner's ramIn <= m_ramIn, owner's readAck = 1 for one cycle.
  - Write completion: owner's writeAck = 1 for one cycle.
  - On completion: free slot, last_grant <= owner, go IDLE.
  - Timeout counter increments each WAIT cycle. On reaching TIMEOUT: complete as if acked, read data = TO_DATA, set err_timeout.
- Latency: request pulse sampled at edge T → m_*Req high after edge T+1 → RAM ack sampled at edge T+k → requester ack high after edge T+k.
  - Minimum total latency: 3 cycles (RAM acks in the first WAIT cycle).
- Data hold: a_ramIn/b_ramIn hold their value until that requester's next read completion. Writes and other-requester traffic do not disturb them.
- Stray m_readAck/m_writeAck in IDLE or ISSUE: ignored, no error.
- Fairness: back-to-back requests from both sides alternate A,B,A,B. No starvation.
- Reset mid-transaction: transaction abandoned, no requester ack generated. A late RAM ack after reset is ignored.
- Sticky error bits clear only on reset.

Test Plan:
- Single read: a_readReq pulse, a_ramAddress=0x10; RAM acks 2 cycles after m_readReq with 0x12345678 → m_ramAddress=0x10 for one req cycle; a_readAck pulses once; a_ramIn=0x12345678; b_* acks stay 0.
- Contention: A write (0x20, 0xAAAA) and B read (0x30) pulsed on the same edge → A issued first; B issued on the next IDLE grant; grant sequence 0,1; err_overflow=0.
- Fairness: both requesters re-request immediately after each ack, 6 transactions → grant order A,B,A,B,A,B.
- Overflow: A pulses a second readReq while its first is in WAIT → err_overflow[0]=1; exactly one a_readAck; second address never appears on m_ramAddress.
- Timeout: TIMEOUT=4, RAM never acks a B read → b_readAck after 4 WAIT cycles; b_ramIn=0xdeadbeef; err_timeout=1; next A request serviced normally.
- Reset: reset_n low during WAIT, RAM acks after release → no requester ack; all outputs 0; state IDLE; next request completes normally.
